ascon_seq: RTL

Job sequencer for the Ascon encryption subsystem. It sits between a dual-port block memory and the `ascon_wrapper` FIFO/control interface. For each job it:
- pulses the core start,
- streams associated-data (AD) and plaintext (PT) words from memory into the wrapper FIFOs,
- drains ciphertext (CT) words back to memory,
- captures the tag.

Software programs base addresses and sizes, then issues `go_i`. Key, nonce and delay go to the wrapper directly and are not handled here.

---
 rtl/ascon_seq_pkg.sv | 34 +++
 rtl/ascon_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ascon_seq_pkg.sv
// Shared types for the Ascon job sequencer: data words, tag, FSM states and
// the helper that picks the first feed state of a job.
package ascon_seq_pkg;

    localparam int BLOCK_WIDTH = 64;

    typedef logic [BLOCK_WIDTH-1:0]   u64_t;
    typedef logic [2*BLOCK_WIDTH-1:0] u128_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        AD_REQ   = 3'd2,
        AD_WAIT  = 3'd3,
        PT_REQ   = 3'd4,
        PT_WAIT  = 3'd5,
        TAG_WAIT = 3'd6,
        DONE     = 3'd7
    } seq_state_e;

    // First phase that still has words to move; TAG_WAIT when both are empty.
    function automatic seq_state_e feed_entry(input logic ad_nz, input logic pt_nz);
        seq_state_e nxt;
        if (ad_nz) begin
            nxt = AD_REQ;
        end else if (pt_nz) begin
            nxt = PT_REQ;
        end else begin
            nxt = TAG_WAIT;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ascon_seq.sv
// Job sequencer between a dual-port word memory and the ascon_wrapper FIFOs:
// feeds AD/PT words, drains CT words back to memory in parallel, captures the tag.
module ascon_seq
    import ascon_seq_pkg::*;
#(
    parameter int DATA_AW = 7,
    parameter int MEM_AW  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go_i,
    input  logic [MEM_AW-1:0]        ad_base_i,
    input  logic [MEM_AW-1:0]        pt_base_i,
    input  logic [MEM_AW-1:0]        ct_base_i,
    input  logic [DATA_AW-1:0]       ad_size_i,
    input  logic [DATA_AW-1:0]       pt_size_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2*BLOCK_WIDTH-1:0] tag_o,
    output logic                     mem_re_o,
    output logic [MEM_AW-1:0]        mem_raddr_o,
    input  logic [BLOCK_WIDTH-1:0]   mem_rdata_i,
    output logic                     mem_we_o,
    output logic [MEM_AW-1:0]        mem_waddr_o,
    output logic [BLOCK_WIDTH-1:0]   mem_wdata_o,
    output logic                     start_o,
    input  logic                     ready_i,
    input  logic                     tag_valid_i,
    input  logic [2*BLOCK_WIDTH-1:0] tag_i,
    output logic                     ad_push_o,
    output logic [BLOCK_WIDTH-1:0]   ad_o,
    input  logic                     ad_full_i,
    output logic                     pt_push_o,
    output logic [BLOCK_WIDTH-1:0]   pt_o,
    input  logic                     pt_full_i,
    output logic                     ct_pop_o,
    input  logic [BLOCK_WIDTH-1:0]   ct_i,
    input  logic                     ct_empty_i
);

    seq_state_e           state_q, state_d;
    logic                 start_q;
    logic [MEM_AW-1:0]    ad_base_q, pt_base_q, ct_base_q;
    logic [DATA_AW-1:0]   ad_size_q, pt_size_q;
    logic [DATA_AW-1:0]   ad_idx_q, pt_idx_q, ct_idx_q, ct_left_q, ct_left_d;
    logic                 tag_seen_q, tag_seen_d;
    u128_t                tag_q;

    logic busy_s, ad_req_s, pt_req_s, ad_push_s, pt_push_s, ct_pop_s, ad_last_s, pt_last_s;

    assign busy_s    = (state_q != IDLE);
    assign ad_req_s  = (state_q == AD_REQ) && !ad_full_i;
    assign pt_req_s  = (state_q == PT_REQ) && !pt_full_i;
    assign ad_push_s = (state_q == AD_WAIT);
    assign pt_push_s = (state_q == PT_WAIT);
    assign ad_last_s = (ad_idx_q == ad_size_q - DATA_AW'(1'b1));
    assign pt_last_s = (pt_idx_q == pt_size_q - DATA_AW'(1'b1));

    // The drain never pops past pt_size words and runs alongside PT feeding.
    assign ct_pop_s   = busy_s && (ct_left_q != '0) && !ct_empty_i;
    assign ct_left_d  = ct_pop_s ? (ct_left_q - DATA_AW'(1'b1)) : ct_left_q;
    assign tag_seen_d = tag_seen_q || (busy_s && tag_valid_i);

    // Data outputs are forced to zero when not qualified so reset clears every port.
    assign busy_o      = busy_s;
    assign done_o      = (state_q == DONE);
    assign start_o     = start_q;
    assign tag_o       = tag_q;
    assign mem_re_o    = ad_req_s || pt_req_s;
    assign mem_raddr_o = ad_req_s ? (ad_base_q + MEM_AW'(ad_idx_q)) :
                         pt_req_s ? (pt_base_q + MEM_AW'(pt_idx_q)) : '0;
    assign ad_push_o   = ad_push_s;
    assign ad_o        = ad_push_s ? mem_rdata_i : '0;
    assign pt_push_o   = pt_push_s;
    assign pt_o        = pt_push_s ? mem_rdata_i : '0;
    assign ct_pop_o    = ct_pop_s;
    assign mem_we_o    = ct_pop_s;
    assign mem_waddr_o = ct_pop_s ? (ct_base_q + MEM_AW'(ct_idx_q)) : '0;
    assign mem_wdata_o = ct_pop_s ? ct_i : '0;

    // Next-state decode of the job FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (go_i) state_d = START; else state_d = IDLE;
            START:    if (start_q) state_d = feed_entry(ad_size_q != '0, pt_size_q != '0);
                      else state_d = START;
            AD_REQ:   if (!ad_full_i) state_d = AD_WAIT; else state_d = AD_REQ;
            AD_WAIT:  if (ad_last_s) state_d = feed_entry(1'b0, pt_size_q != '0);
                      else state_d = AD_REQ;
            PT_REQ:   if (!pt_full_i) state_d = PT_WAIT; else state_d = PT_REQ;
            PT_WAIT:  if (pt_last_s) state_d = TAG_WAIT; else state_d = PT_REQ;
            TAG_WAIT: if (tag_seen_d && (ct_left_d == '0)) state_d = DONE;
                      else state_d = TAG_WAIT;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Job state, latched parameters, index counters and tag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            ad_base_q  <= '0;
            pt_base_q  <= '0;
            ct_base_q  <= '0;
            ad_size_q  <= '0;
            pt_size_q  <= '0;
            ad_idx_q   <= '0;
            pt_idx_q   <= '0;
            ct_idx_q   <= '0;
            ct_left_q  <= '0;
            tag_seen_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q <= state_d;
            // ready_i seen on the go cycle starts the core one cycle later
            start_q <= (((state_q == IDLE) && go_i) || ((state_q == START) && !start_q)) && ready_i;
            if (state_q == IDLE) begin
                if (go_i) begin
                    ad_base_q  <= ad_base_i;
                    pt_base_q  <= pt_base_i;
                    ct_base_q  <= ct_base_i;
                    ad_size_q  <= ad_size_i;
                    pt_size_q  <= pt_size_i;
                    ad_idx_q   <= '0;
                    pt_idx_q   <= '0;
                    ct_idx_q   <= '0;
                    ct_left_q  <= pt_size_i;
                    tag_seen_q <= 1'b0;
                end
            end else begin
                if (ad_push_s) ad_idx_q <= ad_idx_q + DATA_AW'(1'b1);
                if (pt_push_s) pt_idx_q <= pt_idx_q + DATA_AW'(1'b1);
                if (ct_pop_s)  ct_idx_q <= ct_idx_q + DATA_AW'(1'b1);
                ct_left_q  <= ct_left_d;
                tag_seen_q <= tag_seen_d;
                if (tag_valid_i) tag_q <= tag_i;
            end
        end
    end

endmodule
